// File: rtl/multicycle_control_unit.sv
// Control FSM for the multicycle CPU. It decodes the 6-bit opcode from the
// instruction register and drives every datapath strobe. It sequences
// fetch/decode/execute/memory/writeback with a memory-ready handshake, and it
// keeps a count of retired instructions.
module multicycle_control_unit #(
  parameter logic [3:0] ALU_ADD = 4'b0000,
  parameter logic [3:0] ALU_SUB = 4'b0001,
  parameter int         CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op_in,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             irwrite,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             branch_ne,
  output logic [1:0]       pc_src,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_op,
  output logic             illegal,
  output logic [3:0]       state_out,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_ALU_WB   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WB   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10
  } state_t;

  typedef struct packed {
    logic       irwrite;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       illegal;
  } ctrl_t;

  state_t           state, state_nxt;
  ctrl_t            ctrl;
  logic             retire;
  logic [CNT_W-1:0] cnt_q;

  // The zero flag qualifies pc_write_cond inside the datapath. The FSM never looks at it.
  logic unused_zero;
  assign unused_zero = zero;

  // Opcode classification
  logic [1:0] cls;
  logic [3:0] fn;
  logic       is_lw, is_sw, is_br, is_j, legal;
  assign cls   = op_in[5:4];
  assign fn    = op_in[3:0];
  assign is_lw = (cls == 2'b10) && (fn == 4'b0000);
  assign is_sw = (cls == 2'b10) && (fn == 4'b0001);
  assign is_br = (cls == 2'b11) && (fn[3:1] == 3'b000);
  assign is_j  = (cls == 2'b11) && (fn == 4'b0010);
  assign legal = !cls[1] || is_lw || is_sw || is_br || is_j;

  // State register, async active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_nxt;
  end

  // Next-state logic. Unused codes and the single-cycle states fall back to FETCH.
  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:    state_nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (legal) begin
          case (cls)
            2'b00:   state_nxt = S_EXEC_R;
            2'b01:   state_nxt = S_EXEC_I;
            2'b10:   state_nxt = S_MEM_ADDR;
            default: state_nxt = is_j ? S_JUMP : S_BRANCH;
          endcase
        end
      end
      S_EXEC_R,
      S_EXEC_I:   state_nxt = S_ALU_WB;
      S_MEM_ADDR: state_nxt = is_sw ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_nxt = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   state_nxt = mem_ready ? S_FETCH : S_MEM_WR;
      default:    state_nxt = S_FETCH;
    endcase
  end

  // Strobe decode. Everything is held low while reset is asserted, even though the state reads FETCH.
  always_comb begin
    ctrl = '0;
    if (reset) begin
      case (state)
        S_FETCH: begin
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_b = 2'b01;
          ctrl.alu_op    = ALU_ADD;
          ctrl.irwrite   = mem_ready;
          ctrl.pc_write  = mem_ready;
        end
        S_DECODE: begin
          ctrl.alu_src_b = 2'b11;
          ctrl.alu_op    = ALU_ADD;
          ctrl.illegal   = !legal;
        end
        S_EXEC_R: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = 2'b00;
          ctrl.alu_op    = fn;
        end
        S_EXEC_I: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = 2'b10;
          ctrl.alu_op    = fn;
        end
        S_ALU_WB: ctrl.reg_write = 1'b1;
        S_MEM_ADDR: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = 2'b10;
          ctrl.alu_op    = ALU_ADD;
        end
        S_MEM_RD: begin
          ctrl.mem_read = 1'b1;
          ctrl.iord     = 1'b1;
        end
        S_MEM_WB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = 1'b1;
        end
        S_MEM_WR: begin
          ctrl.mem_write = 1'b1;
          ctrl.iord      = 1'b1;
        end
        S_BRANCH: begin
          ctrl.alu_src_a     = 1'b1;
          ctrl.alu_src_b     = 2'b00;
          ctrl.alu_op        = ALU_SUB;
          ctrl.pc_write_cond = 1'b1;
          ctrl.pc_src        = 2'b01;
          ctrl.branch_ne     = op_in[0];
        end
        S_JUMP: begin
          ctrl.pc_write = 1'b1;
          ctrl.pc_src   = 2'b10;
        end
        default: ctrl = '0;
      endcase
    end
  end

  // An instruction retires on the edge that leaves its final state.
  always_comb begin
    retire = 1'b0;
    case (state)
      S_ALU_WB, S_MEM_WB, S_BRANCH, S_JUMP: retire = 1'b1;
      S_MEM_WR:                             retire = mem_ready;
      default:                              retire = 1'b0;
    endcase
  end

  // Retired-instruction counter, wraps silently
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      cnt_q <= '0;
    else if (retire) cnt_q <= cnt_q + 1'b1;
  end

  assign irwrite       = ctrl.irwrite;
  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign branch_ne     = ctrl.branch_ne;
  assign pc_src        = ctrl.pc_src;
  assign iord          = ctrl.iord;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign reg_write     = ctrl.reg_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign illegal       = ctrl.illegal;
  assign state_out     = state;
  assign instr_count   = cnt_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit. Inputs change and outputs are
// sampled just after the falling edge. A second instance with a 4-bit counter
// lets the test reach counter wrap in a few dozen cycles.
module tb_multicycle_control_unit;

  logic        clk;
  logic        reset;
  logic [5:0]  op_in;
  logic        zero;
  logic        mem_ready;
  logic        irwrite, pc_write, pc_write_cond, branch_ne, iord;
  logic        mem_read, mem_write, reg_write, mem_to_reg, alu_src_a, illegal;
  logic [1:0]  pc_src, alu_src_b;
  logic [3:0]  alu_op, state_out;
  logic [15:0] instr_count;
  logic [19:0] strobes;

  logic        s_reset;
  logic [5:0]  s_op;
  logic        s_zero, s_mem_ready;
  logic        s_irwrite, s_pc_write, s_pc_write_cond, s_branch_ne, s_iord;
  logic        s_mem_read, s_mem_write, s_reg_write, s_mem_to_reg, s_alu_src_a, s_illegal;
  logic [1:0]  s_pc_src, s_alu_src_b;
  logic [3:0]  s_alu_op, s_state_out;
  logic [3:0]  s_instr_count;

  int tests = 0;
  int fails = 0;

  assign strobes = {irwrite, pc_write, pc_write_cond, branch_ne, pc_src, iord, mem_read,
                    mem_write, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal};

  multicycle_control_unit #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .op_in(op_in), .zero(zero), .mem_ready(mem_ready),
    .irwrite(irwrite), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .branch_ne(branch_ne), .pc_src(pc_src), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal(illegal),
    .state_out(state_out), .instr_count(instr_count)
  );

  multicycle_control_unit #(.CNT_W(4)) u_small (
    .clk(clk), .reset(s_reset), .op_in(s_op), .zero(s_zero), .mem_ready(s_mem_ready),
    .irwrite(s_irwrite), .pc_write(s_pc_write), .pc_write_cond(s_pc_write_cond),
    .branch_ne(s_branch_ne), .pc_src(s_pc_src), .iord(s_iord), .mem_read(s_mem_read),
    .mem_write(s_mem_write), .reg_write(s_reg_write), .mem_to_reg(s_mem_to_reg),
    .alu_src_a(s_alu_src_a), .alu_src_b(s_alu_src_b), .alu_op(s_alu_op), .illegal(s_illegal),
    .state_out(s_state_out), .instr_count(s_instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    #3;
    tests++; if (strobes !== 20'h0) begin fails++; $display("FAIL reset_strobes: got %h want 0", strobes); end
    tests++; if (state_out !== 4'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", state_out); end
    tests++; if (instr_count !== 16'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", instr_count); end
    repeat (2) @(negedge clk);
    #1;
    tests++; if (strobes !== 20'h0) begin fails++; $display("FAIL reset_held_strobes: got %h want 0", strobes); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests++; if (mem_read !== 1'b1 || irwrite !== 1'b0) begin
      fails++; $display("FAIL fetch_stall: mem_read=%b irwrite=%b want 1/0", mem_read, irwrite); end
  endtask

  task automatic test_add();
    int st[5] = '{0, 1, 2, 4, 0};
    op_in = 6'b000000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); mem_ready = (i < 4); #1;
      tests++; if (state_out !== st[i][3:0]) begin fails++; $display("FAIL add_state[%0d]: got %0d want %0d", i, state_out, st[i]); end
      if (i < 4) begin
        tests++; if (irwrite !== (i == 0) || pc_write !== (i == 0)) begin
          fails++; $display("FAIL add_irwrite_pcw[%0d]: got %b%b want %0d", i, irwrite, pc_write, i == 0); end
        tests++; if (reg_write !== (i == 3)) begin fails++; $display("FAIL add_reg_write[%0d]: got %b", i, reg_write); end
      end
      if (i == 2) begin
        tests++; if (alu_src_a !== 1'b1 || alu_src_b !== 2'b00 || alu_op !== 4'h0) begin
          fails++; $display("FAIL add_exec: a=%b b=%b op=%h want 1/00/0", alu_src_a, alu_src_b, alu_op); end
      end
    end
    tests++; if (instr_count !== 16'd1) begin fails++; $display("FAIL add_count: got %0d want 1", instr_count); end
  endtask

  task automatic test_itype();
    int st[5] = '{0, 1, 3, 4, 0};
    op_in = 6'b010110;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); mem_ready = (i < 4); #1;
      tests++; if (state_out !== st[i][3:0]) begin fails++; $display("FAIL itype_state[%0d]: got %0d want %0d", i, state_out, st[i]); end
      if (i == 1) begin
        tests++; if (alu_src_b !== 2'b11 || alu_op !== 4'h0 || alu_src_a !== 1'b0) begin
          fails++; $display("FAIL decode_alu: b=%b op=%h a=%b want 11/0/0", alu_src_b, alu_op, alu_src_a); end
      end
      if (i == 2) begin
        tests++; if (alu_src_b !== 2'b10 || alu_op !== 4'h6 || alu_src_a !== 1'b1) begin
          fails++; $display("FAIL itype_exec: b=%b op=%h a=%b want 10/6/1", alu_src_b, alu_op, alu_src_a); end
      end
    end
    tests++; if (instr_count !== 16'd2) begin fails++; $display("FAIL itype_count: got %0d want 2", instr_count); end
  endtask

  task automatic test_lw();
    int st[11] = '{0, 0, 0, 1, 5, 6, 6, 6, 6, 7, 0};
    bit rdy[11] = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 0};
    op_in = 6'b100000;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk); mem_ready = rdy[i]; #1;
      tests++; if (state_out !== st[i][3:0]) begin fails++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, state_out, st[i]); end
      if (i < 10) begin
        tests++; if (reg_write !== (i == 9) || mem_to_reg !== (i == 9)) begin
          fails++; $display("FAIL lw_wb[%0d]: reg_write=%b mem_to_reg=%b", i, reg_write, mem_to_reg); end
        tests++; if (iord !== (i >= 5 && i <= 8) || irwrite !== (i == 2)) begin
          fails++; $display("FAIL lw_iord_ir[%0d]: iord=%b irwrite=%b", i, iord, irwrite); end
      end
      if (i == 4) begin
        tests++; if (alu_src_b !== 2'b10 || alu_src_a !== 1'b1 || alu_op !== 4'h0) begin
          fails++; $display("FAIL lw_addr: b=%b a=%b op=%h", alu_src_b, alu_src_a, alu_op); end
      end
      if (i == 6) begin
        tests++; if (mem_read !== 1'b1) begin fails++; $display("FAIL lw_mem_read: got %b want 1", mem_read); end
      end
    end
    tests++; if (instr_count !== 16'd3) begin fails++; $display("FAIL lw_count: got %0d want 3", instr_count); end
  endtask

  task automatic run_branch(input logic [5:0] op, input logic ne, input logic [15:0] cnt);
    int st[4] = '{0, 1, 9, 0};
    op_in = op; zero = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mem_ready = (i < 3); #1;
      tests++; if (state_out !== st[i][3:0]) begin fails++; $display("FAIL br_state[%0d]: got %0d want %0d", i, state_out, st[i]); end
      if (i == 2) begin
        tests++; if (pc_write_cond !== 1'b1 || pc_src !== 2'b01 || alu_op !== 4'h1 || branch_ne !== ne) begin
          fails++; $display("FAIL br_ctrl: pwc=%b src=%b op=%h ne=%b want 1/01/1/%b", pc_write_cond, pc_src, alu_op, branch_ne, ne); end
        tests++; if (alu_src_a !== 1'b1 || alu_src_b !== 2'b00 || pc_write !== 1'b0) begin
          fails++; $display("FAIL br_alu: a=%b b=%b pcw=%b want 1/00/0", alu_src_a, alu_src_b, pc_write); end
      end
    end
    tests++; if (instr_count !== cnt) begin fails++; $display("FAIL br_count: got %0d want %0d", instr_count, cnt); end
  endtask

  task automatic test_branch();
    run_branch(6'b110000, 1'b0, 16'd4);
    run_branch(6'b110001, 1'b1, 16'd5);
    zero = 1'b0;
  endtask

  task automatic test_illegal();
    int st[3] = '{0, 1, 0};
    op_in = 6'b101111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); mem_ready = (i < 2); #1;
      tests++; if (state_out !== st[i][3:0]) begin fails++; $display("FAIL ill_state[%0d]: got %0d want %0d", i, state_out, st[i]); end
      tests++; if (illegal !== (i == 1)) begin fails++; $display("FAIL ill_pulse[%0d]: got %b", i, illegal); end
      tests++; if (reg_write !== 1'b0 || mem_write !== 1'b0) begin
        fails++; $display("FAIL ill_writes[%0d]: reg_write=%b mem_write=%b want 0", i, reg_write, mem_write); end
    end
    tests++; if (instr_count !== 16'd5) begin fails++; $display("FAIL ill_count: got %0d want 5", instr_count); end
  endtask

  task automatic test_jump();
    int st[4] = '{0, 1, 10, 0};
    op_in = 6'b110010;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mem_ready = (i < 3); #1;
      tests++; if (state_out !== st[i][3:0]) begin fails++; $display("FAIL j_state[%0d]: got %0d want %0d", i, state_out, st[i]); end
      if (i == 2) begin
        tests++; if (pc_write !== 1'b1 || pc_src !== 2'b10 || mem_read !== 1'b0) begin
          fails++; $display("FAIL j_ctrl: pcw=%b src=%b mr=%b want 1/10/0", pc_write, pc_src, mem_read); end
      end
    end
    tests++; if (instr_count !== 16'd6) begin fails++; $display("FAIL j_count: got %0d want 6", instr_count); end
  endtask

  task automatic test_sw();
    int st[6] = '{0, 1, 5, 8, 8, 0};
    bit rdy[6] = '{1, 1, 1, 0, 1, 0};
    op_in = 6'b100001;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); mem_ready = rdy[i]; #1;
      tests++; if (state_out !== st[i][3:0]) begin fails++; $display("FAIL sw_state[%0d]: got %0d want %0d", i, state_out, st[i]); end
      if (i < 5) begin
        tests++; if (mem_write !== (i >= 3) || reg_write !== 1'b0) begin
          fails++; $display("FAIL sw_strobes[%0d]: mem_write=%b reg_write=%b", i, mem_write, reg_write); end
      end
      if (i == 3) begin
        tests++; if (instr_count !== 16'd6) begin fails++; $display("FAIL sw_count_wait: got %0d want 6", instr_count); end
      end
    end
    tests++; if (instr_count !== 16'd7) begin fails++; $display("FAIL sw_count: got %0d want 7", instr_count); end
  endtask

  task automatic test_reset_mid();
    int st[4] = '{0, 1, 5, 8};
    bit rdy[4] = '{1, 1, 1, 0};
    op_in = 6'b100001;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mem_ready = rdy[i]; #1;
      tests++; if (state_out !== st[i][3:0]) begin fails++; $display("FAIL rmid_state[%0d]: got %0d want %0d", i, state_out, st[i]); end
    end
    tests++; if (mem_write !== 1'b1) begin fails++; $display("FAIL rmid_mw_before: got %b want 1", mem_write); end
    #1 reset = 1'b0;
    #1;
    tests++; if (mem_write !== 1'b0 || strobes !== 20'h0) begin
      fails++; $display("FAIL rmid_strobes: mem_write=%b strobes=%h want 0", mem_write, strobes); end
    tests++; if (state_out !== 4'd0) begin fails++; $display("FAIL rmid_state: got %0d want 0", state_out); end
    tests++; if (instr_count !== 16'd0) begin fails++; $display("FAIL rmid_count: got %0d want 0", instr_count); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk); #1;
    tests++; if (state_out !== 4'd0 || mem_read !== 1'b1 || mem_write !== 1'b0) begin
      fails++; $display("FAIL rmid_restart: state=%0d mr=%b mw=%b want 0/1/0", state_out, mem_read, mem_write); end
  endtask

  task automatic test_wrap();
    @(negedge clk); s_reset = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      repeat (3) @(negedge clk);
      #1;
      if (k == 15) begin
        tests++; if (s_instr_count !== 4'hF || s_state_out !== 4'd0) begin
          fails++; $display("FAIL wrap_max: count=%h state=%0d want F/0", s_instr_count, s_state_out); end
      end
      if (k == 16) begin
        tests++; if (s_instr_count !== 4'h0 || s_state_out !== 4'd0) begin
          fails++; $display("FAIL wrap_zero: count=%h state=%0d want 0/0", s_instr_count, s_state_out); end
      end
    end
  endtask

  initial begin
    reset = 1'b0; op_in = 6'b0; zero = 1'b0; mem_ready = 1'b0;
    s_reset = 1'b0; s_op = 6'b110010; s_zero = 1'b0; s_mem_ready = 1'b1;
    test_reset();
    test_add();
    test_itype();
    test_lw();
    test_branch();
    test_illegal();
    test_jump();
    test_sw();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
